als_spi_scheduler: RTL and testbench

ALS_SPI_SCHEDULER -- requirements
Module: als_spi_scheduler

---
 rtl/als_spi_scheduler_if.sv | 33 +++
 rtl/als_spi_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_als_spi_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/als_spi_scheduler_if.sv
// Host/sensor signal bundle for als_spi_scheduler: request/ack/readback plus the SPI pins.
interface als_spi_scheduler_if;
    logic [1:0]  req;
    logic [1:0]  ack;
    logic [15:0] rdata;
    logic        cs;
    logic        sck;
    logic        sdo;
    logic [7:0]  value;
    logic        value_valid;

    modport master (
        output req,
        output sdo,
        input  ack,
        input  rdata,
        input  cs,
        input  sck,
        input  value,
        input  value_valid
    );

    modport slave (
        input  req,
        input  sdo,
        output ack,
        output rdata,
        output cs,
        output sck,
        output value,
        output value_valid
    );
endinterface

// File: rtl/als_spi_scheduler.sv
// Round-robin scheduler of 16-bit SPI read frames from an ambient-light sensor.
// Define ALS_AUTO_SAMPLE_EN to add the periodic auto-sample source and value/value_valid.
module als_spi_scheduler #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned QUIET   = 8,
    parameter int unsigned PERIOD  = 1000000
) (
    input logic                clock,
    input logic                reset_n,
    als_spi_scheduler_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StSetup, StShift, StDone, StHold} state_t;

    localparam logic [1:0] SrcTick   = 2'd2;
    localparam logic [7:0] DivLast   = 8'(CLK_DIV - 1);
    localparam logic [7:0] QuietLast = 8'(QUIET - 1);

    state_t      state_q;
    logic [7:0]  div_q;
    logic [3:0]  bit_q;
    logic [15:0] shift_q;
    logic [15:0] rdata_q;
    logic [1:0]  src_q;
    logic [1:0]  ack_q;
    logic        prio_q;
    logic        drop_q;
    logic        cs_q;
    logic        sck_q;
    logic        grant_vld;
    logic [1:0]  grant_src;

`ifdef ALS_AUTO_SAMPLE_EN
    localparam logic [31:0] PeriodLast = 32'(PERIOD - 1);

    logic [31:0] period_q;
    logic        tick_pend_q;
    logic        tick_now;
    logic [7:0]  value_q;
    logic        value_valid_q;

    assign tick_now = (period_q == PeriodLast);
`endif

    // prio_q = 1 means req[1] wins a tie; the tick only goes when no requester waits
    always_comb begin
        grant_vld = 1'b0;
        grant_src = 2'd0;
        if (bus.req == 2'b11) begin
            grant_vld = 1'b1;
            grant_src = {1'b0, prio_q};
        end else if (bus.req[0]) begin
            grant_vld = 1'b1;
            grant_src = 2'd0;
        end else if (bus.req[1]) begin
            grant_vld = 1'b1;
            grant_src = 2'd1;
        end
`ifdef ALS_AUTO_SAMPLE_EN
        else if (tick_pend_q) begin
            grant_vld = 1'b1;
            grant_src = SrcTick;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rdata_q <= '0;
            src_q   <= '0;
            ack_q   <= '0;
            prio_q  <= 1'b0;
            drop_q  <= 1'b0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b1;
`ifdef ALS_AUTO_SAMPLE_EN
            period_q      <= '0;
            tick_pend_q   <= 1'b0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
`ifdef ALS_AUTO_SAMPLE_EN
            value_valid_q <= 1'b0;
            period_q      <= tick_now ? '0 : period_q + 32'd1;
            // A fresh tick wins over the grant that consumes the old one
            if (tick_now) begin
                tick_pend_q <= 1'b1;
            end else if (state_q == StIdle && grant_vld && grant_src == SrcTick) begin
                tick_pend_q <= 1'b0;
            end
`endif
            // Sticky: a requester that lets go mid-frame forfeits its ack
            if (state_q != StIdle && src_q != SrcTick && !bus.req[src_q[0]]) begin
                drop_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    cs_q  <= 1'b1;
                    sck_q <= 1'b1;
                    if (grant_vld) begin
                        state_q <= StSetup;
                        cs_q    <= 1'b0;
                        src_q   <= grant_src;
                        div_q   <= '0;
                        drop_q  <= 1'b0;
                        if (grant_src != SrcTick) begin
                            prio_q <= ~grant_src[0];
                        end
                    end
                end
                StSetup: begin
                    if (div_q == DivLast) begin
                        state_q <= StShift;
                        sck_q   <= 1'b0;
                        div_q   <= '0;
                        bit_q   <= '0;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                StShift: begin
                    if (div_q != DivLast) begin
                        div_q <= div_q + 8'd1;
                    end else begin
                        div_q <= '0;
                        if (!sck_q) begin
                            sck_q   <= 1'b1;
                            shift_q <= {shift_q[14:0], bus.sdo};
                        end else if (bit_q == 4'd15) begin
                            state_q <= StDone;
                            cs_q    <= 1'b1;
                            rdata_q <= shift_q;
                            if (src_q == SrcTick) begin
`ifdef ALS_AUTO_SAMPLE_EN
                                value_q       <= shift_q[12:5];
                                value_valid_q <= 1'b1;
`endif
                            end else begin
                                ack_q[src_q[0]] <= bus.req[src_q[0]] && !drop_q;
                            end
                        end else begin
                            sck_q <= 1'b0;
                            bit_q <= bit_q + 4'd1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StHold;
                    div_q   <= '0;
                end
                StHold: begin
                    if (div_q == QuietLast) begin
                        state_q <= StIdle;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cs    = cs_q;
    assign bus.sck   = sck_q;
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
`ifdef ALS_AUTO_SAMPLE_EN
    assign bus.value       = value_q;
    assign bus.value_valid = value_valid_q;
`else
    assign bus.value       = '0;
    assign bus.value_valid = 1'b0;
`endif
endmodule

// File: tb/tb_als_spi_scheduler.sv
// Bench for als_spi_scheduler: directed table, corner sequences, and random requesters
// checked against a frame-level model with a behavioural sensor.
module tb_als_spi_scheduler;
    localparam int CD   = 2;
    localparam int QT   = 8;
    localparam int PER  = 200;
    localparam int FLEN = CD * 33;

    logic clock = 1'b0;
    logic reset_n = 1'b1;

    als_spi_scheduler_if bus ();

    als_spi_scheduler #(
        .CLK_DIV(CD),
        .QUIET  (QT),
        .PERIOD (PER)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    // Frame-level model state
    bit          in_frame;
    bit          dropped;
    bit          tick_pend;
    bit          use_fixed;
    bit          started_tick;
    int          fcyc;
    int          src;
    int          last_served;
    int          hi_run;
    int          n_edge;
    int          bitidx;
    int          sck_rises;
    logic [15:0] word;
    logic [15:0] fixed_word;
    logic [15:0] last_rdata;
    logic        sck_prev;
    logic [1:0]  ack_exp;
    logic        vv_exp;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic mon();
        logic [1:0]  r;
        logic [31:0] exp_sck;
        r = bus.req;
        ack_exp = 2'b00;
        vv_exp = 1'b0;
        started_tick = 1'b0;
        n_edge++;
        if (in_frame) begin
            fcyc++;
            if (src >= 0 && src < 2 && !r[src]) dropped = 1'b1;
            if (fcyc == FLEN) begin
                in_frame = 1'b0;
                chk("frame_end_cs", 32'(bus.cs), 32'd1);
                chk("frame_sck_rises", 32'(sck_rises), 32'd16);
                chk("rdata", 32'(bus.rdata), 32'(word));
                last_rdata = word;
                if (src >= 0 && src < 2 && !dropped) ack_exp[src] = 1'b1;
                if (src == 2) begin
                    vv_exp = 1'b1;
                    chk("value", 32'(bus.value), 32'(word[12:5]));
                end
            end else begin
                chk("cs_in_frame", 32'(bus.cs), 32'd0);
                exp_sck = (fcyc < CD) ? 32'd1 : 32'(((fcyc - CD) / CD) % 2);
                chk("sck_wave", 32'(bus.sck), exp_sck);
                if (sck_prev == 1'b0 && bus.sck == 1'b1) begin
                    sck_rises++;
                    bitidx--;
                    bus.sdo = (bitidx >= 0) ? word[bitidx] : 1'b0;
                end
            end
        end else if (bus.cs == 1'b0) begin
            chk("quiet_gap", 32'(hi_run >= QT + 2), 32'd1);
            chk("rdata_hold", 32'(bus.rdata), 32'(last_rdata));
            chk("sck_setup", 32'(bus.sck), 32'd1);
            if (r == 2'b11) src = (last_served == 0) ? 1 : 0;
            else if (r[0]) src = 0;
            else if (r[1]) src = 1;
            else if (tick_pend) src = 2;
            else src = -1;
            chk("frame_has_source", 32'(src >= 0), 32'd1);
            if (src == 0 || src == 1) last_served = src;
            started_tick = (src == 2);
            in_frame = 1'b1;
            fcyc = 0;
            dropped = 1'b0;
            sck_rises = 0;
            word = use_fixed ? fixed_word : 16'($urandom);
            bitidx = 15;
            bus.sdo = word[15];
        end else begin
            chk("sck_idle", 32'(bus.sck), 32'd1);
            chk("grant_latency", 32'(((r != 2'b00) || tick_pend) && hi_run >= QT + 2), 32'd0);
        end
        chk("ack", 32'(bus.ack), 32'(ack_exp));
`ifdef ALS_AUTO_SAMPLE_EN
        chk("value_valid", 32'(bus.value_valid), 32'(vv_exp));
        if (n_edge % PER == 0) tick_pend = 1'b1;
        else if (started_tick) tick_pend = 1'b0;
`else
        chk("value_tied", 32'({bus.value, bus.value_valid}), 32'd0);
`endif
        hi_run = bus.cs ? hi_run + 1 : 0;
        sck_prev = bus.sck;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        mon();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_cs", 32'(bus.cs), 32'd1);
        chk("rst_sck", 32'(bus.sck), 32'd1);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_value", 32'({bus.value, bus.value_valid}), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        in_frame = 1'b0;
        n_edge = 0;
        tick_pend = 1'b0;
        last_served = 1;
        hi_run = 1000;
        sck_prev = 1'b1;
        last_rdata = '0;
    endtask

    task automatic wait_ack(input int max, output logic [1:0] a, output int n);
        a = 2'b00;
        n = 0;
        while (n < max && a == 2'b00) begin
            step();
            n++;
            a = bus.ack;
        end
        if (a == 2'b00) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (n < max && (in_frame || hi_run < QT + 2)) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(in_frame || hi_run < QT + 2), 32'd0);
    endtask

    task automatic rand_drive();
        for (int i = 0; i < 2; i++) begin
            if (bus.ack[i]) begin
                bus.req[i] = 1'b0;
            end else if (!bus.req[i]) begin
                if (!(in_frame && src == i) && $urandom_range(0, 7) == 0) bus.req[i] = 1'b1;
            end else if ($urandom_range(0, 99) == 0) begin
                bus.req[i] = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [15:0] word;
        logic [1:0]  ack;
    } vec_t;

    initial begin
        vec_t        tbl [5];
        logic [1:0]  a;
        int          n;
        int          cnt;
        int          guard;

        tbl[0] = '{2'b01, 16'h0FA0, 2'b01};
        tbl[1] = '{2'b10, 16'h1234, 2'b10};
        tbl[2] = '{2'b01, 16'hFFFF, 2'b01};
        tbl[3] = '{2'b10, 16'h0000, 2'b10};
        tbl[4] = '{2'b11, 16'hC35A, 2'b01};

        bus.req = 2'b00;
        bus.sdo = 1'b0;
        use_fixed = 1'b1;
        fixed_word = 16'h0FA0;
        #3;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            do_reset();
            fixed_word = tbl[i].word;
            bus.req = tbl[i].req;
            step();
            chk("t_cs_latency", 32'(bus.cs), 32'd0);
            wait_ack(200, a, n);
            chk("t_ack", 32'(a), 32'(tbl[i].ack));
            chk("t_rdata", 32'(bus.rdata), 32'(tbl[i].word));
            chk("t_ack_time", 32'(n), 32'(FLEN));
            bus.req = 2'b00;
            wait_idle(100);
        end

        // Both held: req[0] first, quiet gap, then req[1]; then re-assert both
        do_reset();
        fixed_word = 16'h1111;
        bus.req = 2'b11;
        wait_ack(200, a, n);
        chk("rr_first", 32'(a), 32'd1);
        bus.req[0] = 1'b0;
        wait_ack(200, a, n);
        chk("rr_second", 32'(a), 32'd2);
        chk("rr_gap", 32'(n), 32'(FLEN + QT + 2));
        bus.req[1] = 1'b0;
        wait_idle(100);
        bus.req = 2'b11;
        wait_ack(200, a, n);
        chk("rr_not_req1_first", 32'(a), 32'd1);
        bus.req = 2'b00;
        wait_idle(100);

        // Reset 30 clocks into a frame, then a clean restart
        do_reset();
        fixed_word = 16'h0FA0;
        bus.req = 2'b01;
        step();
        repeat (30) step();
        do_reset();
        step();
        chk("rst_restart_cs", 32'(bus.cs), 32'd0);
        wait_ack(200, a, n);
        chk("rst_restart_ack", 32'(a), 32'd1);
        chk("rst_restart_time", 32'(n), 32'(FLEN));
        chk("rst_restart_rdata", 32'(bus.rdata), 32'h0FA0);
        bus.req = 2'b00;
        wait_idle(100);

        // req[0] dropped 20 clocks into its frame
        do_reset();
        fixed_word = 16'hA5C3;
        bus.req = 2'b01;
        step();
        repeat (20) step();
        bus.req = 2'b00;
        guard = 0;
        while (in_frame && guard < 100) begin
            step();
            guard++;
        end
        chk("drop_ack", 32'(bus.ack), 32'd0);
        chk("drop_rdata", 32'(bus.rdata), 32'hA5C3);
        wait_idle(100);

`ifdef ALS_AUTO_SAMPLE_EN
        // Auto sampling alone: one pulse per period, value = rdata[12:5]
        do_reset();
        fixed_word = 16'h0FA0;
        cnt = 0;
        repeat (700) begin
            step();
            if (bus.value_valid) cnt++;
        end
        chk("auto_pulses", 32'(cnt), 32'd3);
        chk("auto_value", 32'(bus.value), 32'h7D);

        // Tick on the same clock as req[1]: request first, then the auto frame
        do_reset();
        repeat (199) step();
        bus.req = 2'b10;
        step();
        chk("coinc_cs", 32'(bus.cs), 32'd0);
        wait_ack(200, a, n);
        chk("coinc_ack", 32'(a), 32'd2);
        chk("coinc_no_vv_yet", 32'(bus.value_valid), 32'd0);
        bus.req = 2'b00;
        cnt = 0;
        repeat (100) begin
            step();
            if (bus.value_valid) cnt++;
        end
        chk("coinc_vv_once", 32'(cnt), 32'd1);
`endif

        // Random requesters against the model
        do_reset();
        use_fixed = 1'b0;
        bus.req = 2'b00;
        repeat (4000) begin
            step();
            rand_drive();
        end
        bus.req = 2'b00;
        wait_idle(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
